// File: rtl/video_timing_out.sv
// video_timing_out
// Raster timing generator and HDMI output stage.
//
// The generator walks hCount/vCount over the full raster and decodes
// DE/HSYNC/VSYNC from the counters. During active video it requests pixels
// from the upstream RGB source by asserting pixelRequest with pixelX/pixelY.
// The upstream source answers PIXEL_LATENCY cycles later. The decoded
// DE/syncs are delayed by the same number of cycles, so the data and the
// controls meet at one output register.
//
// Optional build macro: TEST_PATTERN_EN adds the testPattern input. When
// testPattern is high, the output shows eight vertical colour bars instead
// of pixelData.
//
// Ports:
//   clock        pixel clock (only clock)
//   reset        synchronous, active-high reset (has priority over enable)
//   enable       run the raster; low holds the counters at (0,0)
//   testPattern  (TEST_PATTERN_EN only) select colour bars over pixelData
//   pixelData    RGB {R,G,B} from upstream, valid PIXEL_LATENCY after request
//   pixelRequest high while the current position is active video
//   pixelX/Y     active coordinates, 0 when pixelRequest is low
//   frameStart   one-cycle pulse at position (0,0)
//   hdmiData     registered RGB, 0 during blanking
//   hdmiDE       registered data enable
//   hdmiHSync    registered HSYNC, active level HS_POL
//   hdmiVSync    registered VSYNC, active level VS_POL
module video_timing_out #(
  parameter int H_ACTIVE      = 1920,
  parameter int H_FRONT       = 88,
  parameter int H_SYNC        = 44,
  parameter int H_BACK        = 148,
  parameter int V_ACTIVE      = 1080,
  parameter int V_FRONT       = 4,
  parameter int V_SYNC        = 5,
  parameter int V_BACK        = 36,
  parameter bit HS_POL        = 1'b1,
  parameter bit VS_POL        = 1'b1,
  parameter int PIXEL_LATENCY = 1    // legal range 1..4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
`ifdef TEST_PATTERN_EN
  input  logic        testPattern,
`endif
  input  logic [23:0] pixelData,
  output logic        pixelRequest,
  output logic [11:0] pixelX,
  output logic [10:0] pixelY,
  output logic        frameStart,
  output logic [23:0] hdmiData,
  output logic        hdmiDE,
  output logic        hdmiHSync,
  output logic        hdmiVSync
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [11:0] hCountReg, hCountNext;
  logic [10:0] vCountReg, vCountNext;

  // Raster counters. While the generator is idle, the counters are held at
  // (0,0). This makes the first enabled cycle the top-left pixel.
  always_comb begin
    hCountNext = hCountReg;
    vCountNext = vCountReg;
    if (!enable) begin
      hCountNext = '0;
      vCountNext = '0;
    end else if (hCountReg == H_LAST) begin
      hCountNext = '0;
      vCountNext = (vCountReg == V_LAST) ? 11'd0 : vCountReg + 11'd1;
    end else begin
      hCountNext = hCountReg + 12'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hCountReg <= '0;
      vCountReg <= '0;
    end else begin
      hCountReg <= hCountNext;
      vCountReg <= vCountNext;
    end
  end

  // Stage 0 decode. The decode is gated by reset as well as enable. This
  // stops a stale (0,0) from producing a request or a frame pulse while
  // reset is still held.
  logic running, de0, hs0, vs0;
  assign running = enable && !reset;
  assign de0 = running && (hCountReg < H_ACT) && (vCountReg < V_ACT);
  assign hs0 = running && (hCountReg >= HS_START) && (hCountReg < HS_END);
  assign vs0 = running && (vCountReg >= VS_START) && (vCountReg < VS_END);

  assign pixelRequest = de0;
  assign pixelX       = de0 ? hCountReg : 12'd0;
  assign pixelY       = de0 ? vCountReg : 11'd0;
  assign frameStart   = running && (hCountReg == 12'd0) && (vCountReg == 11'd0);

  // Delay line that matches the upstream pixel latency. Each stage holds the
  // "active" meaning of the sync signals. Polarity is applied only at the
  // output register.
  for (genvar gi = 0; gi < PIXEL_LATENCY; gi++) begin : stageGen
    logic deIn, hsIn, vsIn;
    logic deStage, hsStage, vsStage;
`ifdef TEST_PATTERN_EN
    logic [11:0] xIn, xStage;
`endif
    if (gi == 0) begin : firstStage
      assign deIn = de0;
      assign hsIn = hs0;
      assign vsIn = vs0;
`ifdef TEST_PATTERN_EN
      assign xIn  = pixelX;
`endif
    end else begin : laterStage
      assign deIn = stageGen[gi-1].deStage;
      assign hsIn = stageGen[gi-1].hsStage;
      assign vsIn = stageGen[gi-1].vsStage;
`ifdef TEST_PATTERN_EN
      assign xIn  = stageGen[gi-1].xStage;
`endif
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        deStage <= 1'b0;
        hsStage <= 1'b0;
        vsStage <= 1'b0;
`ifdef TEST_PATTERN_EN
        xStage  <= '0;
`endif
      end else begin
        deStage <= deIn;
        hsStage <= hsIn;
        vsStage <= vsIn;
`ifdef TEST_PATTERN_EN
        xStage  <= xIn;
`endif
      end
    end
  end

  logic        deDly, hsDly, vsDly;
  logic [23:0] srcData;
  assign deDly = stageGen[PIXEL_LATENCY-1].deStage;
  assign hsDly = stageGen[PIXEL_LATENCY-1].hsStage;
  assign vsDly = stageGen[PIXEL_LATENCY-1].vsStage;

`ifdef TEST_PATTERN_EN
  localparam int          BAR_W   = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
  localparam logic [11:0] BAR_W_V = 12'(BAR_W);

  // Any column past the eighth bar (H_ACTIVE not divisible by 8) is shown
  // as black, which is the same colour as the last bar.
  function automatic logic [23:0] barColour(input logic [11:0] x);
    logic [11:0] barIdx;
    barIdx = x / BAR_W_V;
    case (barIdx)
      12'd0:   return 24'hFFFFFF;
      12'd1:   return 24'hFFFF00;
      12'd2:   return 24'h00FFFF;
      12'd3:   return 24'h00FF00;
      12'd4:   return 24'hFF00FF;
      12'd5:   return 24'hFF0000;
      12'd6:   return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  assign srcData = testPattern ? barColour(stageGen[PIXEL_LATENCY-1].xStage)
                               : pixelData;
`else
  assign srcData = pixelData;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      hdmiData  <= 24'h000000;
      hdmiDE    <= 1'b0;
      hdmiHSync <= ~HS_POL;
      hdmiVSync <= ~VS_POL;
    end else begin
      hdmiData  <= deDly ? srcData : 24'h000000;
      hdmiDE    <= deDly;
      hdmiHSync <= hsDly ? HS_POL : ~HS_POL;
      hdmiVSync <= vsDly ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_video_timing_out.sv
module tb_video_timing_out;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int LAT = 1;
  localparam int HT = HA + HF + HSW + HB;   // 14
  localparam int VT = VA + VF + VSW + VB;   // 7
  localparam int FRAME = HT * VT;           // 98
  localparam int MAXC = 6000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, enable;
  logic [23:0] pixelData;
`ifdef TEST_PATTERN_EN
  logic        testPattern;
`endif

  logic        reqA, fsA, deA, hsA, vsA;
  logic [11:0] pxA;
  logic [10:0] pyA;
  logic [23:0] dA;
  logic        reqB, fsB, deB, hsB, vsB;
  logic [11:0] pxB;
  logic [10:0] pyB;
  logic [23:0] dB;

  video_timing_out #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIXEL_LATENCY(LAT)
  ) dutPos (
    .clock(clock), .reset(reset), .enable(enable),
`ifdef TEST_PATTERN_EN
    .testPattern(testPattern),
`endif
    .pixelData(pixelData), .pixelRequest(reqA), .pixelX(pxA), .pixelY(pyA),
    .frameStart(fsA), .hdmiData(dA), .hdmiDE(deA), .hdmiHSync(hsA), .hdmiVSync(vsA)
  );

  video_timing_out #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIXEL_LATENCY(LAT)
  ) dutNeg (
    .clock(clock), .reset(reset), .enable(enable),
`ifdef TEST_PATTERN_EN
    .testPattern(testPattern),
`endif
    .pixelData(pixelData), .pixelRequest(reqB), .pixelX(pxB), .pixelY(pyB),
    .frameStart(fsB), .hdmiData(dB), .hdmiDE(deB), .hdmiHSync(hsB), .hdmiVSync(vsB)
  );

  int tests = 0;
  int fails = 0;
  int cyc = -1;
  bit done = 1'b0;

  // Per-cycle stimulus record and model state.
  bit          rstA [MAXC];
  bit          enA  [MAXC];
  bit          tpA  [MAXC];
  logic [12:0] rndA [MAXC];
  int          idxA [MAXC];
  bit          de0A [MAXC];
  bit          hs0A [MAXC];
  bit          vs0A [MAXC];
  int          xA   [MAXC];
  int          yA   [MAXC];
  // Observed outputs of the positive-polarity instance.
  bit          obsFs [MAXC];
  bit          obsDe [MAXC];
  bit          obsHs [MAXC];
  bit          obsVs [MAXC];
  logic [23:0] obsData [MAXC];

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic [11:0] reqX;
  logic [10:0] reqY;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] barOf(input int x);
    int b;
    b = x / ((HA / 8 < 1) ? 1 : HA / 8);
    if (b > 7) b = 7;
    return bars[b];
  endfunction

  // One clock: drive the inputs for the next cycle and record them. The
  // upstream source answers the request it saw in the previous cycle.
  task automatic driveCycle(input bit r, input bit e, input bit tp, input logic [12:0] rnd);
    @(posedge clock);
    #1;
    cyc++;
    reset     = r;
    enable    = e;
    pixelData = {rnd, reqY[2:0], reqX[7:0]};
`ifdef TEST_PATTERN_EN
    testPattern = tp;
`endif
    rstA[cyc] = r;
    enA[cyc]  = e;
    tpA[cyc]  = tp;
    rndA[cyc] = rnd;
  endtask

  // Reference model: each cycle is a linear position in the frame. The
  // position restarts at 0 after any reset or idle cycle, and otherwise
  // advances by one modulo the frame length.
  int          mIdx, mH, mV, c;
  bit          mRun, eDe, eHs, eVs;
  logic [23:0] eData;
  logic [11:0] xv;
  logic [10:0] yv;

  always @(negedge clock) begin
    if (cyc >= 0 && cyc < MAXC) begin
      reqX = pxA;
      reqY = pyA;
    end
    if (!done && cyc >= 1 && cyc < MAXC) begin
      c = cyc;
      mIdx = (rstA[c-1] || !enA[c-1]) ? 0 : (idxA[c-1] + 1) % FRAME;
      idxA[c] = mIdx;
      mRun = enA[c] && !rstA[c];
      mH = mIdx % HT;
      mV = mIdx / HT;
      de0A[c] = mRun && mH < HA && mV < VA;
      hs0A[c] = mRun && mH >= HA + HF && mH < HA + HF + HSW;
      vs0A[c] = mRun && mV >= VA + VF && mV < VA + VF + VSW;
      xA[c] = de0A[c] ? mH : 0;
      yA[c] = de0A[c] ? mV : 0;

      check("pixelRequest", {31'd0, reqA}, {31'd0, de0A[c]});
      check("pixelX", {20'd0, pxA}, xA[c]);
      check("pixelY", {21'd0, pyA}, yA[c]);
      check("frameStart", {31'd0, fsA}, {31'd0, mRun && mIdx == 0});

      if (rstA[c-1] || c >= 2) begin
        if (rstA[c-1]) begin
          eDe = 0; eHs = 0; eVs = 0; eData = 24'h0;
        end else begin
          eDe = de0A[c-2];
          eHs = hs0A[c-2];
          eVs = vs0A[c-2];
          xv = 12'(xA[c-2]);
          yv = 11'(yA[c-2]);
          if (!eDe)          eData = 24'h0;
          else if (tpA[c-1]) eData = barOf(xA[c-2]);
          else               eData = {rndA[c-1], yv[2:0], xv[7:0]};
        end
        check("hdmiDE", {31'd0, deA}, {31'd0, eDe});
        check("hdmiData", {8'd0, dA}, {8'd0, eData});
        check("hdmiHSync", {31'd0, hsA}, {31'd0, eHs});
        check("hdmiVSync", {31'd0, vsA}, {31'd0, eVs});
        check("negHSync", {31'd0, hsB}, {31'd0, !eHs});
        check("negVSync", {31'd0, vsB}, {31'd0, !eVs});
        check("negDE", {31'd0, deB}, {31'd0, eDe});
        check("negData", {8'd0, dB}, {8'd0, eData});
      end

      obsFs[c] = fsA;
      obsDe[c] = deA;
      obsHs[c] = hsA;
      obsVs[c] = vsA;
      obsData[c] = dA;
    end
  end

  int  f0, vsCount, d, rcyc, s, rstLeft, disLeft;
  bit  found, r, e;

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    pixelData = 24'h0;
    reqX = '0;
    reqY = '0;
`ifdef TEST_PATTERN_EN
    testPattern = 1'b0;
`endif
    cyc = 0;
    rstA[0] = 1; enA[0] = 1; tpA[0] = 0; rndA[0] = '0;

    // Three reset cycles, then two full frames with zero filler data.
    driveCycle(1, 1, 0, '0);
    driveCycle(1, 1, 0, '0);
    f0 = cyc + 1;
    for (int i = 0; i < 2 * FRAME + 6; i++) driveCycle(0, 1, 0, '0);

    // Hand-computed timing pins for the first frame.
    check("fsFirst", {31'd0, obsFs[f0]}, 32'd1);
    check("fsNext", {31'd0, obsFs[f0 + 1]}, 32'd0);
    check("fsPeriod", {31'd0, obsFs[f0 + 98]}, 32'd1);
    check("fsPeriod2", {31'd0, obsFs[f0 + 196]}, 32'd1);
    check("fsEarly", {31'd0, obsFs[f0 + 97]}, 32'd0);
    check("hsPre", {31'd0, obsHs[f0 + 11]}, 32'd0);
    check("hsOn12", {31'd0, obsHs[f0 + 12]}, 32'd1);
    check("hsOn13", {31'd0, obsHs[f0 + 13]}, 32'd1);
    check("hsOff14", {31'd0, obsHs[f0 + 14]}, 32'd0);
    check("hsLine1", {31'd0, obsHs[f0 + 26]}, 32'd1);
    check("vsPre", {31'd0, obsVs[f0 + 71]}, 32'd0);
    check("vsStart", {31'd0, obsVs[f0 + 72]}, 32'd1);
    check("vsLast", {31'd0, obsVs[f0 + 85]}, 32'd1);
    check("vsEnd", {31'd0, obsVs[f0 + 86]}, 32'd0);
    vsCount = 0;
    for (int i = 0; i < FRAME; i++) vsCount += obsVs[f0 + i];
    check("vsCount", vsCount, 32'd14);
    check("deLat1", {31'd0, obsDe[f0 + 1]}, 32'd0);
    check("deLat2", {31'd0, obsDe[f0 + 2]}, 32'd1);
    check("dataX3", {8'd0, obsData[f0 + 5]}, 32'h000003);
    check("dataY1X5", {8'd0, obsData[f0 + 21]}, 32'h000105);
    check("dataBlank", {8'd0, obsData[f0 + 10]}, 32'h0);

    // Drop enable right after the pixel at column 3.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      driveCycle(0, 1, 0, 13'($urandom));
      #1;
      if (reqA && pxA == 12'd3) found = 1;
    end
    check("waitX3", {31'd0, found}, 32'd1);
    driveCycle(0, 0, 0, '0);
    d = cyc;
    driveCycle(0, 0, 0, '0);
    driveCycle(0, 0, 0, '0);
    #1;
    check("dropDE", {31'd0, deA}, 32'd0);
    check("dropHs", {31'd0, hsA}, 32'd0);
    check("dropVs", {31'd0, vsA}, 32'd0);
    driveCycle(0, 1, 0, '0);
    #1;
    check("reenFs", {31'd0, fsA}, 32'd1);
    check("reenX", {20'd0, pxA}, 32'd0);

    // Reset mid-line 2 while the negative-polarity HSYNC is active.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      driveCycle(0, 1, 0, 13'($urandom));
      @(negedge clock);
      #1;
      if (idxA[cyc] / HT == 2 && hsB == 1'b0) found = 1;
    end
    check("waitLine2", {31'd0, found}, 32'd1);
    driveCycle(1, 1, 0, '0);
    driveCycle(0, 1, 0, '0);
    #1;
    check("rstNegHs", {31'd0, hsB}, 32'd1);
    check("rstDE", {31'd0, deB}, 32'd0);
    check("rstData", {8'd0, dB}, 32'd0);
    check("rstFs", {31'd0, fsA}, 32'd1);
    check("rstX", {20'd0, pxA}, 32'd0);

    // Random run with occasional reset and enable-drop bursts.
    rstLeft = 0;
    disLeft = 0;
    for (int i = 0; i < 2000; i++) begin
      r = 0;
      e = 1;
      if (rstLeft > 0) begin
        r = 1; rstLeft--;
      end else if ($urandom_range(0, 399) == 0) begin
        r = 1; rstLeft = $urandom_range(0, 2);
      end
      if (disLeft > 0) begin
        e = 0; disLeft--;
      end else if ($urandom_range(0, 199) == 0) begin
        e = 0; disLeft = $urandom_range(0, 5);
      end
      driveCycle(r, e, 0, 13'($urandom));
    end

`ifdef TEST_PATTERN_EN
    driveCycle(1, 1, 1, '0);
    driveCycle(0, 1, 1, 13'($urandom));
    s = cyc;
    for (int i = 0; i < 120; i++) driveCycle(0, 1, 1, 13'($urandom));
    for (int k = 0; k < 8; k++) check("bar", {8'd0, obsData[s + 2 + k]}, {8'd0, bars[k]});
    check("barBlank", {8'd0, obsData[s + 10]}, 32'h0);
`endif

    driveCycle(0, 1, 0, '0);
    driveCycle(0, 1, 0, '0);
    @(negedge clock);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_timing_out.md
Name: video_timing_out

Overview:
Video timing generator and output stage that sits directly downstream of the 24-bit RGB pixel source and feeds the HDMI transmitter. It produces the raster timing: horizontal/vertical counters, DE, HSYNC and VSYNC. It issues pixel requests with X/Y coordinates to the upstream source and realigns the returned 24-bit RGB data with delayed sync/DE, so the HDMI module receives a coherent registered pixel bus.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FRONT, 88, horizontal front porch (pixels)
H_SYNC, 44, HSYNC width (pixels)
H_BACK, 148, horizontal back porch (pixels)
V_ACTIVE, 1080, active lines per frame
V_FRONT, 4, vertical front porch (lines)
V_SYNC, 5, VSYNC width (lines)
V_BACK, 36, vertical back porch (lines)
HS_POL, 1, HSYNC active level (1 = active-high)
VS_POL, 1, VSYNC active level
PIXEL_LATENCY, 1, cycles from pixelRequest to valid pixelData; legal range 1..4

Ports:
clock  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high reset
enable  in  1  run raster; low holds generator idle
pixelData  in  24  RGB from upstream {R[23:16],G[15:8],B[7:0]}, valid PIXEL_LATENCY cycles after request
pixelRequest  out  1  high when current position is active video
pixelX  out  12  active column 0..H_ACTIVE-1; 0 when pixelRequest low
pixelY  out  11  active line 0..V_ACTIVE-1; 0 when pixelRequest low
frameStart  out  1  one-cycle pulse at position (0,0)
hdmiData  out  24  registered RGB to HDMI; 0 during blanking
hdmiDE  out  1  registered data enable
hdmiHSync  out  1  registered HSYNC, polarity HS_POL
hdmiVSync  out  1  registered VSYNC, polarity VS_POL

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Counters hCount (12b) and vCount (11b) are registered.
  - hCount wraps H_TOTAL-1 -> 0 and increments vCount.
  - vCount wraps V_TOTAL-1 -> 0 when hCount wraps.
- Stage 0, decoded from the counters:
  - de0 = hCount<H_ACTIVE && vCount<V_ACTIVE
  - hs0 active for hCount in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC)
  - vs0 active for vCount in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC); spans whole lines and changes at hCount==0
- pixelRequest = de0. pixelX/pixelY = hCount/vCount when de0, else 0. frameStart = enable && hCount==0 && vCount==0. All are aligned with stage 0.
- de0/hs0/vs0 pass through a PIXEL_LATENCY-deep shift pipeline, then one output register.
  - Request at cycle N: pixelData sampled at N+PIXEL_LATENCY; hdmi* outputs valid at N+PIXEL_LATENCY+1.
  - Fixed total latency is PIXEL_LATENCY+1 for data and syncs alike.
- hdmiData = pixelData when the delayed DE is 1, else 24'h000000.
- enable low:
  - Counters are forced to (0,0) and frameStart/pixelRequest are suppressed.
  - The pipeline keeps shifting with DE=0 and syncs inactive, so outputs reach the idle state within PIXEL_LATENCY+1 cycles.
  - When enable rises, the first enabled cycle is (0,0) with frameStart=1.
- reset (synchronous, active-high):
  - Counters = 0; all pipeline stages cleared (DE 0, syncs inactive).
  - hdmiData = 0, hdmiDE = 0, hdmiHSync = ~HS_POL, hdmiVSync = ~VS_POL, pixelRequest = 0, frameStart = 0.
  - Reset has priority over enable.
  - Mid-frame reset aborts the frame; the first cycle after release with enable high is (0,0) with frameStart.
- No partial lines or frames other than those caused by reset or enable drop. Parameters are static.

Optional Feature:
TEST_PATTERN_EN
- Defined:
  - Adds input port testPattern (1b).
  - When testPattern is high, hdmiData ignores pixelData and outputs 8 vertical colour bars derived from the delayed pixelX.
  - Bar width is H_ACTIVE/8. Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Output is still 0 during blanking; latency is unchanged.
  - testPattern is sampled per pixel and may change mid-frame.
- Undefined: port absent; hdmiData always sourced from pixelData.

Test Plan:
(Small config for all: H_ACTIVE=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_ACTIVE=4, V_FRONT=1, V_SYNC=1, V_BACK=1, PIXEL_LATENCY=1; H_TOTAL=14, V_TOTAL=7, frame = 98 cycles.)
1. Reset 3 cycles, then enable=1.
   - Required: frameStart at first cycle; pixelRequest high 8 cycles with pixelX 0..7, low 6.
   - hdmiHSync high at line cycles 12..13 (hCount 10,11 +2); line period 14.
2. Upstream model returns pixelData = {13'b0, pixelY[2:0], pixelX[7:0]} one cycle after request.
   - Required: hdmiData equals it 2 cycles after request, hdmiDE coincident, 0 in blanking.
3. Run 2 full frames.
   - Required: hdmiVSync high exactly 14 cycles per frame, starting 72 cycles after frameStart; frameStart period 98.
4. Drop enable at pixelX=3.
   - Required: hdmiDE 0 within 2 cycles; syncs inactive.
   - Re-assert enable: frameStart same cycle, pixelX=0.
5. Assert reset mid-line 2 with HS_POL=0.
   - Required: next cycle hdmiHSync=1, hdmiDE=0, hdmiData=0.
   - After release, frame restarts at (0,0).
6. TEST_PATTERN_EN defined, testPattern=1.
   - Required: active line outputs FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 on consecutive pixels; blanking 0.
